decode_stage: RTL and testbench

Instruction decode stage of the five-stage RV32I pipelined processor and the consumer of the fetch stage's decode-side interface. It takes InstrD/PCD/PCPlus4D from fetch, and returns PCSrcD/JalD/PCTargetD to fetch, with branches and jumps resolved in decode. It holds the architectural register file, generates control, extends immediates and registers everything into the ID/EX pipeline register.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/register_file.sv | 23 ++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 128 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, control encodings, immediate formats and ID/EX layout
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_fmt_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    imm_fmt_t   imm_fmt;
  } ctrl_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } idex_t;
  function automatic logic [31:0] imm_ext(input logic [31:0] i, input imm_fmt_t f);
    return f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
           f == IMM_U ? {i[31:12], 12'b0} :
                        {{20{i[31]}}, i[31:20]};
  endfunction
endpackage

// File: rtl/register_file.sv
// register_file: 32x32 regs, two async read ports with write-through bypass, x0 hardwired to zero
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [32];
  logic wr;
  assign wr = we && wa != 5'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wr)
      regs[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : (wr && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (wr && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with control, immediates, branch resolution and the ID/EX register
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUResultM,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic        FlushE,
  output logic        PCSrcD,
  output logic        JalD,
  output logic [31:0] PCTargetD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);
  logic [6:0] op, f7;
  logic [2:0] f3, f3_alu;
  logic f3_ok, taken;
  logic [31:0] rd1, rd2, imm, a, b, jalr_sum;
  ctrl_t c;
  idex_t d, e;
  assign op = InstrD[6:0];
  assign f3 = InstrD[14:12];
  assign f7 = InstrD[31:25];
  assign f3_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010;
  assign f3_alu = f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR : f3 == 3'b010 ? ALU_SLT : ALU_ADD;
  always_comb begin
    c = '0;
    case (op)
      OP_R:
        if (f3_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000))) begin
          c.reg_write = 1'b1;
          c.alu_ctrl = f7[5] ? ALU_SUB : f3_alu;
        end
      OP_I:
        if (f3_ok) begin
          c.reg_write = 1'b1;
          c.alu_src = 1'b1;
          c.alu_ctrl = f3_alu;
        end
      OP_LOAD:
        if (f3 == 3'b010) begin
          c.reg_write = 1'b1;
          c.alu_src = 1'b1;
          c.result_src = RES_MEM;
        end
      OP_STORE:
        if (f3 == 3'b010) begin
          c.mem_write = 1'b1;
          c.alu_src = 1'b1;
          c.imm_fmt = IMM_S;
        end
      OP_BRANCH:
        if (f3[2:1] == 2'b00) begin
          c.branch = 1'b1;
          c.alu_ctrl = ALU_SUB;
          c.imm_fmt = IMM_B;
        end
      OP_JAL: begin
        c.reg_write = 1'b1;
        c.jal = 1'b1;
        c.result_src = RES_PC4;
        c.imm_fmt = IMM_J;
      end
      OP_JALR:
        if (f3 == 3'b000) begin
          c.reg_write = 1'b1;
          c.jalr = 1'b1;
          c.alu_src = 1'b1;
          c.result_src = RES_PC4;
        end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src = 1'b1;
        c.imm_fmt = IMM_U;
      end
      default: ;
    endcase
  end
  // lui reads x0 so the ALU produces 0 + imm
  assign Rs1D = op == OP_LUI ? 5'd0 : InstrD[19:15];
  assign Rs2D = InstrD[24:20];
  register_file u_rf (
    .clk(clk), .rst(rst), .we(RegWriteW), .wa(RdW), .wd(ResultW),
    .ra1(Rs1D), .ra2(Rs2D), .rd1(rd1), .rd2(rd2)
  );
  assign imm = imm_ext(InstrD, c.imm_fmt);
  assign a = ForwardAD ? ALUResultM : rd1;
  assign b = ForwardBD ? ALUResultM : rd2;
  assign taken = c.branch && ((a == b) ^ f3[0]);
  assign jalr_sum = a + imm;
  assign PCSrcD = !rst && (taken || c.jal || c.jalr);
  assign JalD = c.jal || c.jalr;
  assign PCTargetD = c.jalr ? {jalr_sum[31:1], 1'b0} : PCD + imm;
  assign d = '{reg_write: c.reg_write, mem_write: c.mem_write, alu_src: c.alu_src,
               result_src: c.result_src, alu_ctrl: c.alu_ctrl, rd1: rd1, rd2: rd2,
               imm: imm, pc4: PCPlus4D, rd: InstrD[11:7], rs1: Rs1D, rs2: Rs2D};
  always_ff @(posedge clk or posedge rst)
    if (rst) e <= '0;
    else e <= FlushE ? '0 : d;
  assign RegWriteE = e.reg_write;
  assign MemWriteE = e.mem_write;
  assign ALUSrcE = e.alu_src;
  assign ResultSrcE = e.result_src;
  assign ALUControlE = e.alu_ctrl;
  assign RD1E = e.rd1;
  assign RD2E = e.rd2;
  assign ImmExtE = e.imm;
  assign PCPlus4E = e.pc4;
  assign RdE = e.rd;
  assign Rs1E = e.rs1;
  assign Rs2E = e.rs2;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0, ALUResultM = '0;
  logic RegWriteW = 1'b0, ForwardAD = 1'b0, ForwardBD = 1'b0, FlushE = 1'b0;
  logic [4:0] RdW = '0;
  logic PCSrcD, JalD, RegWriteE, MemWriteE, ALUSrcE;
  logic [31:0] PCTargetD, RD1E, RD2E, ImmExtE, PCPlus4E;
  logic [4:0] Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  int tests = 0, fails = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .ALUResultM(ALUResultM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .JalD(JalD), .PCTargetD(PCTargetD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic setreg(input logic [4:0] r, input logic [31:0] v);
    RegWriteW = 1'b1; RdW = r; ResultW = v;
    step();
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
  endtask
  initial begin
    InstrD = 32'h004380E7;
    #1;
    check("rst_pcsrc_held", {31'b0, PCSrcD}, 0);
    check("rst_regwritee", {31'b0, RegWriteE}, 0);
    step();
    step();
    rst = 1'b0;
    InstrD = 32'h00028333;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h1234;
    step();
    check("bypass_rd1e", RD1E, 32'h1234);
    check("bypass_rde", {27'b0, RdE}, 6);
    RdW = 5'd0; ResultW = 32'hFFFF; InstrD = 32'h00000333;
    step();
    RegWriteW = 1'b0;
    check("x0_rd1e", RD1E, 0);
    check("x0_rd2e", RD2E, 0);
    InstrD = 32'h00700293;
    step();
    check("addi_regwrite", {31'b0, RegWriteE}, 1);
    check("addi_alusrc", {31'b0, ALUSrcE}, 1);
    check("addi_aluctrl", {29'b0, ALUControlE}, 0);
    check("addi_imm", ImmExtE, 7);
    check("addi_rd", {27'b0, RdE}, 5);
    check("addi_ressrc", {30'b0, ResultSrcE}, 0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_regwrite", {31'b0, RegWriteE}, 0);
    check("async_rst_imm", ImmExtE, 0);
    check("async_rst_rd", {27'b0, RdE}, 0);
    check("async_rst_alusrc", {31'b0, ALUSrcE}, 0);
    step();
    rst = 1'b0;
    InstrD = 32'h00028333;
    step();
    check("x5_cleared", RD1E, 0);
    setreg(5'd1, 32'd3);
    setreg(5'd2, 32'd3);
    setreg(5'd7, 32'h203);
    PCD = 32'h100; InstrD = 32'hFE208CE3;
    #1;
    check("beq_taken", {31'b0, PCSrcD}, 1);
    check("beq_target", PCTargetD, 32'hF8);
    check("beq_jald", {31'b0, JalD}, 0);
    setreg(5'd2, 32'd4);
    check("beq_not_taken", {31'b0, PCSrcD}, 0);
    ForwardBD = 1'b1; ALUResultM = 32'd3;
    #1;
    check("beq_fwd_taken", {31'b0, PCSrcD}, 1);
    ForwardBD = 1'b0; ALUResultM = '0;
    PCD = 32'h300; PCPlus4D = 32'h304; InstrD = 32'h004380E7;
    #1;
    check("jalr_pcsrc", {31'b0, PCSrcD}, 1);
    check("jalr_jald", {31'b0, JalD}, 1);
    check("jalr_target", PCTargetD, 32'h206);
    step();
    check("jalr_ressrc", {30'b0, ResultSrcE}, 2);
    check("jalr_pc4e", PCPlus4E, 32'h304);
    check("jalr_rd", {27'b0, RdE}, 1);
    InstrD = 32'h00512423;
    step();
    check("sw_memwrite", {31'b0, MemWriteE}, 1);
    check("sw_regwrite", {31'b0, RegWriteE}, 0);
    check("sw_imm", ImmExtE, 8);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    check("flush_memwrite", {31'b0, MemWriteE}, 0);
    check("flush_imm", ImmExtE, 0);
    check("flush_rs1e", {27'b0, Rs1E}, 0);
    check("flush_alusrc", {31'b0, ALUSrcE}, 0);
    InstrD = 32'hFFFFFFFF;
    #1;
    check("nop_pcsrc", {31'b0, PCSrcD}, 0);
    check("nop_jald", {31'b0, JalD}, 0);
    step();
    check("nop_regwrite", {31'b0, RegWriteE}, 0);
    check("nop_memwrite", {31'b0, MemWriteE}, 0);
    InstrD = 32'h123451B7;
    #1;
    check("lui_rs1d", {27'b0, Rs1D}, 0);
    step();
    check("lui_imm", ImmExtE, 32'h12345000);
    check("lui_alusrc", {31'b0, ALUSrcE}, 1);
    check("lui_rd1e", RD1E, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
